// File: rtl/pci_txn_if.sv
// PCI transaction sequencer bus bundle.
// Carries the shared PCI control lines, the device-side request inputs and
// the sequencer status outputs. The sequencer connects through the slave
// modport; the environment (device datapath / bus model) uses master.
//
// Handshake semantics: all PCI control lines are active-low. A data phase
// transfer completes on a rising clk edge where the sequencer is in DATA and
// irdy, trdy and devsel are all sampled low; data_valid reflects exactly that
// condition combinationally during the cycle before the edge. There is no
// back-pressure on the status outputs: they are registered and must be
// consumed on the cycle they are presented.
interface pci_txn_if #(
  parameter int CNT_W = 4
);
  logic             frame;
  logic             irdy;
  logic             trdy;
  logic             devsel;
  logic             stop;
  logic             req;
  logic             gnt;
  logic             rd_wr;
  logic [CNT_W-1:0] burst_len;

  logic [2:0]       state;
  logic             bus_is_mine;
  logic             data_valid;
  logic [CNT_W-1:0] xfer_count;
  logic             done;
  logic             target_stop;
  logic             master_abort;

  modport slave (
    input  frame, irdy, trdy, devsel, stop, req, gnt, rd_wr, burst_len,
    output state, bus_is_mine, data_valid, xfer_count, done, target_stop,
           master_abort
  );

  modport master (
    output frame, irdy, trdy, devsel, stop, req, gnt, rd_wr, burst_len,
    input  state, bus_is_mine, data_valid, xfer_count, done, target_stop,
           master_abort
  );
endinterface

// File: rtl/pci_txn_sequencer.sv
// PCI bus-phase sequencer.
// Follows own (initiator) and snooped transactions through the address,
// turnaround, data and finish phases, counts completed data transfers and
// reports target stop and master abort (DEVSEL# timeout) terminations.
// Optional feature macro: LATENCY_TIMER_EN adds a latency timer that ends an
// own burst early once the grant has been removed and the timer has expired.
module pci_txn_sequencer #(
  parameter int MAX_BURST      = 8,
  parameter int TURN_CYCLES    = 1,
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int LAT_CYCLES     = 16
) (
  input logic      clk,
  input logic      rst_n,
  pci_txn_if.slave bus
);

  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int TMO_W  = (DEVSEL_TIMEOUT > 1) ? $clog2(DEVSEL_TIMEOUT) : 1;

  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DEVSEL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BURST);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDRESS = 3'd1,
    ST_TURN    = 3'd2,
    ST_DATA    = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ABORT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              mine_q;
  logic              rd_q;
  logic [CNT_W-1:0]  blen_q;
  logic [CNT_W-1:0]  blen_clamped;
  logic [CNT_W-1:0]  cnt_q;
  logic [TURN_W-1:0] turn_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              done_q;
  logic              tstop_q;
  logic              mabort_q;

  logic data_valid;
  logic start_own;
  logic start_snoop;
  logic stop_exit;
  logic last_beat;
  logic tmo_hit;

  assign data_valid = (state_q == ST_DATA) & ~bus.irdy & ~bus.trdy & ~bus.devsel;
  assign last_beat  = data_valid && mine_q &&
                      (({1'b0, cnt_q} + 1'b1) == {1'b0, blen_q});
  // tmo_q holds the number of preceding consecutive DATA cycles without devsel
  assign tmo_hit    = bus.devsel && (tmo_q == TMO_LAST);

`ifdef LATENCY_TIMER_EN
  localparam int LAT_W = $clog2(LAT_CYCLES + 1);

  logic [LAT_W-1:0] lat_q;
  logic             lat_exit;

  // Expiry is judged on the count this DATA cycle brings to zero, so a reload
  // of N lets N data cycles run; a transfer in flight is allowed to complete.
  always_comb begin
    lat_exit = (state_q == ST_DATA) && (lat_q <= LAT_W'(1)) && bus.gnt &&
               mine_q && (data_valid || bus.irdy);
  end

  // Latency timer: reload in ADDRESS, count down through the data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state_q == ST_ADDRESS) begin
      lat_q <= LAT_W'(LAT_CYCLES);
    end else if ((state_q == ST_DATA) && (lat_q != '0)) begin
      lat_q <= lat_q - 1'b1;
    end
  end
`else
  logic unused_lat_cfg;
  assign unused_lat_cfg = (LAT_CYCLES != 0);
`endif

  // Zero requests one data phase; oversize requests are cut to MAX_BURST
  always_comb begin
    blen_clamped = bus.burst_len;
    if (bus.burst_len == '0) begin
      blen_clamped = CNT_W'(1);
    end else if (int'(bus.burst_len) > MAX_BURST) begin
      blen_clamped = CNT_MAX;
    end
  end

  // Next-state decode and phase-exit qualifiers
  always_comb begin
    state_d     = state_q;
    start_own   = 1'b0;
    start_snoop = 1'b0;
    stop_exit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.req && !bus.gnt) begin
          state_d   = ST_ADDRESS;
          start_own = 1'b1;
        end else if (!bus.frame) begin
          state_d     = (bus.rd_wr && (TURN_CYCLES > 0)) ? ST_TURN : ST_DATA;
          start_snoop = 1'b1;
        end
      end
      ST_ADDRESS: begin
        state_d = (rd_q && (TURN_CYCLES > 0)) ? ST_TURN : ST_DATA;
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!bus.stop) begin
          state_d   = ST_FINISH;
          stop_exit = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ABORT;
`ifdef LATENCY_TIMER_EN
        end else if (lat_exit) begin
          state_d = ST_FINISH;
`endif
        end else if (last_beat) begin
          state_d = ST_FINISH;
        end else if (data_valid && bus.frame) begin
          state_d = ST_FINISH;
        end
      end
      ST_ABORT:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register, transaction attributes and termination pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mine_q   <= 1'b0;
      rd_q     <= 1'b0;
      blen_q   <= '0;
      done_q   <= 1'b0;
      tstop_q  <= 1'b0;
      mabort_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_d == ST_FINISH) && (state_q != ST_FINISH);
      tstop_q  <= stop_exit;
      mabort_q <= (state_d == ST_ABORT);
      if (start_own) begin
        mine_q <= 1'b1;
        rd_q   <= bus.rd_wr;
        blen_q <= blen_clamped;
      end else if (start_snoop) begin
        mine_q <= 1'b0;
        rd_q   <= bus.rd_wr;
      end else if (state_q == ST_FINISH) begin
        mine_q <= 1'b0;
      end
    end
  end

  // Phase counters: transfer count, turnaround length, devsel timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      turn_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (start_own || start_snoop || (state_q == ST_ADDRESS)) begin
        cnt_q <= '0;
      end else if (data_valid && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if ((state_q == ST_TURN) && (state_d == ST_TURN)) begin
        turn_q <= turn_q + 1'b1;
      end else begin
        turn_q <= '0;
      end

      if ((state_q == ST_DATA) && (state_d == ST_DATA) && bus.devsel) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.bus_is_mine  = mine_q;
  assign bus.data_valid   = data_valid;
  assign bus.xfer_count   = cnt_q;
  assign bus.done         = done_q;
  assign bus.target_stop  = tstop_q;
  assign bus.master_abort = mabort_q;

endmodule
